// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, 3-sample majority vote, optional
// parity, one or two stop bits, valid/ready delivery with parity/framing/overrun pulses.
module uart_rx_param #(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_data,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int D  = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW = $clog2(D);
    localparam logic [CW-1:0] T_START   = CW'(D / 2);
    localparam logic [CW-1:0] T_BIT     = CW'(D - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE, WAIT_HIGH} state_e;

    state_e               state_q;
    logic [1:0]           sync_q;
    logic [1:0]           hist_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] sr_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    logic rx_s;
    logic vote;

    assign rx_s = sync_q[1];
    // hist_q holds rx_s from the two previous cycles, so the vote covers T-2, T-1, T.
    assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together on the edge, regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            hist_q       <= 2'b11;
            cnt_q        <= '0;
            bit_q        <= '0;
            sr_q         <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], i_data};
            hist_q       <= {hist_q[0], rx_s};
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            if (valid_q && i_ready) valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // The IDLE cycle that first sees the low line counts as 0.
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == T_START) begin
                        cnt_q <= '0;
                        if (vote) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            bit_q   <= '0;
                            perr_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == T_BIT) begin
                        cnt_q <= '0;
                        sr_q  <= {vote, sr_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_DATA) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PAR: begin
                    if (cnt_q == T_BIT) begin
                        cnt_q   <= '0;
                        perr_q  <= (PARITY == 1) ? ~(^sr_q ^ vote) : (^sr_q ^ vote);
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == T_BIT) begin
                        cnt_q <= '0;
                        if (!vote) ferr_q <= 1'b1;
                        if (bit_q == LAST_STOP) begin
                            bit_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (ferr_q) begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_HIGH;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (perr_q) begin
                            parity_err_q <= 1'b1;
                        end else begin
                            data_q    <= sr_q;
                            valid_q   <= 1'b1;
                            overrun_q <= valid_q && !i_ready;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances (8N1, 7E1, 8N2) at D=16,
// expected events queued by the stimulus, popped by a negedge monitor.
module tb_uart_rx_param;

    localparam int D = 16;

    typedef enum {EV_VALID, EV_PERR, EV_FERR, EV_OVR} ev_e;
    typedef struct {
        int         dut;
        ev_e        kind;
        logic [8:0] data;
    } exp_t;

    logic            clk;
    logic [2:0]      line;
    logic [2:0]      rdy;
    logic [2:0]      rstn;
    logic [2:0][8:0] dout;
    logic [2:0]      vld;
    logic [2:0]      perr;
    logic [2:0]      ferr;
    logic [2:0]      ovr;
    logic [2:0]      busy;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t0       = 0;
    int   rise_cyc = 0;
    int   vrun     = 0;
    int   last_run = 0;
    int   brun     = 0;
    int   bmax     = 0;
    logic [2:0] vld_prev = 3'b000;

    assign dout[0][8]   = 1'b0;
    assign dout[1][8:7] = 2'b00;
    assign dout[2][8]   = 1'b0;

    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst_n(rstn[0]), .i_data(line[0]), .i_ready(rdy[0]),
        .o_data(dout[0][7:0]), .o_valid(vld[0]), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .o_busy(busy[0]));

    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .i_clk(clk), .i_rst_n(rstn[1]), .i_data(line[1]), .i_ready(rdy[1]),
        .o_data(dout[1][6:0]), .o_valid(vld[1]), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .o_busy(busy[1]));

    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .i_clk(clk), .i_rst_n(rstn[2]), .i_data(line[2]), .i_ready(rdy[2]),
        .o_data(dout[2][7:0]), .o_valid(vld[2]), .o_parity_err(perr[2]),
        .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .o_busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input ev_e k, input logic [8:0] dat);
        exp_t e;
        e.dut  = d;
        e.kind = k;
        e.data = dat;
        sb_q.push_back(e);
    endtask

    task automatic expect_ev(input int d, input ev_e k, input logic [8:0] dat);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected dut=%0d got=%s data=%h required=none", d, k.name(), dat);
        end else begin
            e = sb_q.pop_front();
            if (e.dut != d || e.kind != k || ((k == EV_VALID || k == EV_OVR) && e.data != dat)) begin
                failures++;
                $display("FAIL sb_event actual=dut%0d %s %h required=dut%0d %s %h",
                         d, k.name(), dat, e.dut, e.kind.name(), e.data);
            end
        end
    endtask

    // Monitor: every output event is matched against the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ferr[d]) expect_ev(d, EV_FERR, 9'h0);
            if (perr[d]) expect_ev(d, EV_PERR, 9'h0);
            if (ovr[d]) expect_ev(d, EV_OVR, dout[d]);
            else if (vld[d] && !vld_prev[d]) expect_ev(d, EV_VALID, dout[d]);
        end
        if (vld[0] && !vld_prev[0]) rise_cyc = cyc;
        if (vld[0]) vrun++;
        else if (vrun > 0) begin
            last_run = vrun;
            vrun     = 0;
        end
        if (busy[0]) begin
            brun++;
            if (brun > bmax) bmax = brun;
        end else begin
            brun = 0;
        end
        vld_prev = vld;
    end

    task automatic mk(input logic [8:0] data, input int nd, input int par, input int ns,
                      output logic [15:0] bits, output int n);
        bits    = '1;
        n       = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < nd; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (par >= 0) begin
            bits[n] = par[0];
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            bits[n] = 1'b1;
            n++;
        end
    endtask

    task automatic send(input int d, input logic [15:0] bits, input int n,
                        input int glitch_at, input int rst_at);
        logic b;
        t0 = cyc;
        for (int c = 0; c < n * D; c++) begin
            b = bits[c / D];
            line[d] = (c == glitch_at) ? ~b : b;
            if (c == rst_at) rstn[d] = 1'b0;
            if (rst_at >= 0 && c == rst_at + 1) begin
                check("rst_mid_outputs_zero",
                      32'({dout[d], vld[d], perr[d], ferr[d], ovr[d], busy[d]}), 32'd0);
                rstn[d] = 1'b1;
            end
            @(negedge clk);
        end
        line[d] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] fb;
    int          fn;

    initial begin
        line = 3'b111;
        rdy  = 3'b011;
        rstn = 3'b000;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check("reset_outputs_zero",
                  32'({dout[d], vld[d], perr[d], ferr[d], ovr[d], busy[d]}), 32'd0);
        rstn = 3'b111;
        idle(5);

        // 8N1 0xA5, clean line: latency and single-cycle valid with ready held high.
        push(0, EV_VALID, 9'h0A5);
        mk(9'h0A5, 8, -1, 1, fb, fn);
        send(0, fb, fn, -1, -1);
        idle(40);
        check("valid_latency_window", 32'((rise_cyc - t0 >= 148) && (rise_cyc - t0 <= 160)), 32'd1);
        check("valid_one_cycle", 32'(last_run), 32'd1);

        // Same frame with a one-clock high glitch at the middle of bit 3.
        push(0, EV_VALID, 9'h0A5);
        send(0, fb, fn, 4 * D + D / 2 - 1, -1);
        idle(40);

        // Four-clock low pulse on an idle line is a false start.
        bmax    = 0;
        line[0] = 1'b0;
        idle(4);
        line[0] = 1'b1;
        idle(40);
        check("false_start_busy_le8", 32'((bmax >= 1) && (bmax <= 8)), 32'd1);
        check("false_start_idle", 32'(busy[0]), 32'd0);

        // Break: 12 bit times low yields one framing error, then a good frame.
        push(0, EV_FERR, 9'h0);
        line[0] = 1'b0;
        idle(12 * D);
        line[0] = 1'b1;
        idle(2 * D);
        check("break_recovered_idle", 32'(busy[0]), 32'd0);
        push(0, EV_VALID, 9'h03C);
        mk(9'h03C, 8, -1, 1, fb, fn);
        send(0, fb, fn, -1, -1);
        idle(40);

        // 7E1: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right.
        push(1, EV_PERR, 9'h0);
        mk(9'h007, 7, 0, 1, fb, fn);
        send(1, fb, fn, -1, -1);
        idle(40);
        check("parity_err_no_valid", 32'(vld[1]), 32'd0);
        push(1, EV_VALID, 9'h007);
        mk(9'h007, 7, 1, 1, fb, fn);
        send(1, fb, fn, -1, -1);
        idle(40);

        // 8N2 back-to-back with ready low: second completion overruns.
        push(2, EV_VALID, 9'h011);
        push(2, EV_OVR, 9'h022);
        mk(9'h011, 8, -1, 2, fb, fn);
        send(2, fb, fn, -1, -1);
        mk(9'h022, 8, -1, 2, fb, fn);
        send(2, fb, fn, -1, -1);
        idle(10);
        check("overrun_valid_held", 32'(vld[2]), 32'd1);
        check("overrun_data_new", 32'(dout[2]), 32'h022);
        rdy[2] = 1'b1;
        idle(2);
        check("overrun_drained", 32'(vld[2]), 32'd0);

        // Same pair with ready high throughout: no overrun.
        push(2, EV_VALID, 9'h011);
        push(2, EV_VALID, 9'h022);
        mk(9'h011, 8, -1, 2, fb, fn);
        send(2, fb, fn, -1, -1);
        mk(9'h022, 8, -1, 2, fb, fn);
        send(2, fb, fn, -1, -1);
        idle(40);

        // Reset pulse during data bit 4 of 0xFF abandons it; next frame is clean.
        mk(9'h0FF, 8, -1, 1, fb, fn);
        send(0, fb, fn, -1, 5 * D + D / 2);
        idle(20);
        push(0, EV_VALID, 9'h05A);
        mk(9'h05A, 8, -1, 1, fb, fn);
        send(0, fb, fn, -1, -1);
        idle(40);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
